lap_stopwatch: RTL and testbench
================================

LAP_STOPWATCH -- requirements
Module: lap_stopwatch

Interface
REQ-001 SHALL have parameter CLK_HZ, default 2000000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, count rate in Hz (one tick = one outMS step).
REQ-003 SHALL have parameter LAP_DEPTH, default 4, number of lap slots, range 1..8.
REQ-004 SHALL have port clk_2MHz  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ASSERT  input  1  command qualifier; buttons ignored when low.
REQ-007 SHALL have port in_set  input  1  start/stop toggle.
REQ-008 SHALL have port in_op1  input  1  lap capture when running, clear when stopped.
REQ-009 SHALL have port in_op2  input  1  lap recall step.
REQ-010 SHALL have ports outMM, outSS, outMS  output  7 each  displayed minutes 0..99, seconds 0..59, hundredths 0..99.
REQ-011 SHALL have port running  output  1  high while counting.
REQ-012 SHALL have port lap_view  output  1  high while a stored lap is displayed.
REQ-013 SHALL have port lap_count  output  4  number of stored laps, 0..LAP_DEPTH.
REQ-014 SHALL have port lap_full  output  1  high when lap_count == LAP_DEPTH.
REQ-015 SHALL have port overflow  output  1  high once the count saturates.

Function
REQ-016 SHALL use prescaler DIV = CLK_HZ/TICK_HZ; when running, prescaler counts 0..DIV-1; tick fires in the cycle it equals DIV-1, then it returns to 0.
REQ-017 SHALL hold the prescaler when stopped, so accumulated sub-tick time is preserved across stop/start.
REQ-018 SHALL advance MS on tick; MS 99->0 carries to SS; SS 59->0 carries to MM.
REQ-019 SHALL saturate at 99:59.99: further ticks ignored, overflow set to 1, running unchanged.
REQ-020 SHALL decode at most one command per cycle, only when ASSERT=1, priority in_set > in_op1 > in_op2.
REQ-021 SHALL toggle running on in_set; the toggle is visible on running the next cycle, and a tick in the same cycle is still applied.
REQ-022 SHALL, on in_op1 while running, store the current pre-tick time into slot lap_count and increment lap_count; when lap_full, discard the capture with no overwrite.
REQ-023 SHALL, on in_op1 while stopped, zero time, prescaler, lap_count, recall index, lap_view and overflow in one cycle.
REQ-024 SHALL, on in_op2 with lap_count=0, do nothing.
REQ-025 SHALL, on in_op2 with lap_count>0, step through laps: live -> slot 0 -> ... -> slot lap_count-1 -> live. lap_view=1 while showing a slot.
REQ-026 SHALL drive outMM/outSS/outMS from the selected slot when lap_view=1, else from the live count; counting continues underneath.
REQ-027 SHALL derive outputs from registers only, with no input-to-output combinational path.
REQ-028 SHALL support an unsynthesisable check that CLK_HZ mod TICK_HZ = 0 and DIV >= 2.

Reset
REQ-029 SHALL, on reset_n low, asynchronously force time 00:00.00, prescaler 0, running 0, lap_count 0, recall index 0, lap_view 0, lap_full 0 and overflow 0.
REQ-030 SHALL treat lap slot contents as don't-care after reset, since they are never displayed before being written.
REQ-031 SHALL accept the first command on the first rising edge after reset_n rises.

Configuration
REQ-032 SHALL define LAP_STOPWATCH_RECALL_EN: when defined, REQ-024..026 behave as written.
REQ-033 SHALL, when LAP_STOPWATCH_RECALL_EN is undefined, ignore in_op2, tie lap_view to 0 and always display live time; lap capture and lap_count are retained.

Verification (CLK_HZ=200, TICK_HZ=100, DIV=2, LAP_DEPTH=2)
REQ-034 SHALL verify: reset, then ASSERT+in_set pulse, then 200 cycles -> running=1, display 00:01.00.
REQ-035 SHALL verify: run to 00:00.37, in_op1, in_op1, in_op1 -> lap_count=2, lap_full=1, third capture dropped, slots hold captured times.
REQ-036 SHALL verify: with 2 laps, in_op2 x3 -> lap_view 1,1,0; displays slot0, slot1, then live; live count unaffected.
REQ-037 SHALL verify: stop, then in_op1 -> 00:00.00, lap_count=0, overflow=0; in_op1 with ASSERT=0 -> no change.
REQ-038 SHALL verify: preload near 99:59.98 by forcing, then run 10 ticks -> holds 99:59.99, overflow=1.
REQ-039 SHALL verify: reset_n low mid-count between edges -> all outputs cleared immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lap_stopwatch.sv
// lap_stopwatch -- hundredths-resolution stopwatch with lap capture and recall.
//
// Purpose:
//   Counts MM:SS.hh at TICK_HZ from a CLK_HZ clock, saturating at 99:59.99.
//   Button commands (qualified by ASSERT, priority in_set > in_op1 > in_op2)
//   start/stop the count, capture laps or clear, and step through stored laps.
//
// Ports:
//   clk_2MHz            in   sole clock, rising edge
//   reset_n             in   asynchronous active-low reset
//   ASSERT              in   command qualifier; buttons ignored when low
//   in_set              in   start/stop toggle
//   in_op1              in   lap capture while running, clear while stopped
//   in_op2              in   lap recall step
//   outMM/outSS/outMS   out  displayed minutes/seconds/hundredths (7 bits each)
//   running             out  high while counting
//   lap_view            out  high while a stored lap is displayed
//   lap_count           out  number of stored laps (0..LAP_DEPTH)
//   lap_full            out  lap_count == LAP_DEPTH
//   overflow            out  set once the count saturates
//
// Configuration macro:
//   LAP_STOPWATCH_RECALL_EN  defined   -> lap slots stored and recallable via in_op2
//                            undefined -> in_op2 ignored, lap_view tied 0,
//                                         display always shows live time
module lap_stopwatch #(
  parameter int CLK_HZ    = 2000000,
  parameter int TICK_HZ   = 100,
  parameter int LAP_DEPTH = 4
) (
  input  logic       clk_2MHz,
  input  logic       reset_n,
  input  logic       ASSERT,
  input  logic       in_set,
  input  logic       in_op1,
  input  logic       in_op2,
  output logic [6:0] outMM,
  output logic [6:0] outSS,
  output logic [6:0] outMS,
  output logic       running,
  output logic       lap_view,
  output logic [3:0] lap_count,
  output logic       lap_full,
  output logic       overflow
);

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int PRE_W  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int SLOT_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

  // Elaboration-time configuration check (simulation/lint only effect).
  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2 || LAP_DEPTH < 1 || LAP_DEPTH > 8) begin : g_bad_cfg
    $error("lap_stopwatch: CLK_HZ must be a multiple of TICK_HZ with DIV >= 2, LAP_DEPTH in 1..8");
  end

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [6:0]       mm_q, mm_d, ss_q, ss_d, ms_q, ms_d;
  logic             running_q, running_d;
  logic [3:0]       lap_cnt_q, lap_cnt_d;
  logic             ovf_q, ovf_d;

  logic tick, at_max, full;
  logic cmd_set, cmd_op1;
  logic capture, clear;

  assign tick    = running_q && (pre_q == PRE_W'(DIV - 1));
  assign at_max  = (mm_q == 7'd99) && (ss_q == 7'd59) && (ms_q == 7'd99);
  assign full    = (lap_cnt_q == 4'(LAP_DEPTH));

  // Priority decode: one command per cycle at most.
  assign cmd_set = ASSERT & in_set;
  assign cmd_op1 = ASSERT & ~in_set & in_op1;

  // A capture stores the pre-tick time; a capture when full is dropped.
  assign capture = cmd_op1 & running_q & ~full;
  assign clear   = cmd_op1 & ~running_q;

`ifdef LAP_STOPWATCH_RECALL_EN
  // Recall index: 0 = live, k = slot k-1.
  logic [3:0] idx_q, idx_d;
  logic       view_q, view_d;
  logic       cmd_op2;
  logic [3:0] sel;
  logic [6:0] slot_mm [LAP_DEPTH];
  logic [6:0] slot_ss [LAP_DEPTH];
  logic [6:0] slot_ms [LAP_DEPTH];

  assign cmd_op2 = ASSERT & ~in_set & ~in_op1 & in_op2;
  assign sel     = idx_q - 4'd1;
`else
  logic unused_op2;
  assign unused_op2 = in_op2;
`endif

  always_comb begin
    pre_d     = pre_q;
    mm_d      = mm_q;
    ss_d      = ss_q;
    ms_d      = ms_q;
    running_d = running_q;
    lap_cnt_d = lap_cnt_q;
    ovf_d     = ovf_q;
`ifdef LAP_STOPWATCH_RECALL_EN
    idx_d     = idx_q;
    view_d    = view_q;
`endif

    // Prescaler only advances while running so sub-tick time survives a stop.
    if (running_q) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end

    if (tick) begin
      if (at_max) begin
        ovf_d = 1'b1;
      end else if (ms_q == 7'd99) begin
        ms_d = 7'd0;
        if (ss_q == 7'd59) begin
          ss_d = 7'd0;
          mm_d = mm_q + 7'd1;
        end else begin
          ss_d = ss_q + 7'd1;
        end
      end else begin
        ms_d = ms_q + 7'd1;
      end
    end

    if (cmd_set) begin
      running_d = ~running_q;
    end

    if (capture) begin
      lap_cnt_d = lap_cnt_q + 4'd1;
    end

`ifdef LAP_STOPWATCH_RECALL_EN
    if (cmd_op2 && lap_cnt_q != 4'd0) begin
      if (idx_q == lap_cnt_q) begin
        idx_d  = 4'd0;
        view_d = 1'b0;
      end else begin
        idx_d  = idx_q + 4'd1;
        view_d = 1'b1;
      end
    end
`endif

    // Clear only happens while stopped, so no tick competes with it.
    if (clear) begin
      pre_d     = '0;
      mm_d      = 7'd0;
      ss_d      = 7'd0;
      ms_d      = 7'd0;
      lap_cnt_d = 4'd0;
      ovf_d     = 1'b0;
`ifdef LAP_STOPWATCH_RECALL_EN
      idx_d     = 4'd0;
      view_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_2MHz or negedge reset_n) begin
    if (!reset_n) begin
      pre_q     <= '0;
      mm_q      <= 7'd0;
      ss_q      <= 7'd0;
      ms_q      <= 7'd0;
      running_q <= 1'b0;
      lap_cnt_q <= 4'd0;
      ovf_q     <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      mm_q      <= mm_d;
      ss_q      <= ss_d;
      ms_q      <= ms_d;
      running_q <= running_d;
      lap_cnt_q <= lap_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef LAP_STOPWATCH_RECALL_EN
  always_ff @(posedge clk_2MHz or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= 4'd0;
      view_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      view_q <= view_d;
    end
  end

  // Slot storage has no reset: a slot is always written before it can be shown.
  always_ff @(posedge clk_2MHz) begin
    if (capture) begin
      slot_mm[lap_cnt_q[SLOT_W-1:0]] <= mm_q;
      slot_ss[lap_cnt_q[SLOT_W-1:0]] <= ss_q;
      slot_ms[lap_cnt_q[SLOT_W-1:0]] <= ms_q;
    end
  end

  assign lap_view = view_q;
  assign outMM    = view_q ? slot_mm[sel[SLOT_W-1:0]] : mm_q;
  assign outSS    = view_q ? slot_ss[sel[SLOT_W-1:0]] : ss_q;
  assign outMS    = view_q ? slot_ms[sel[SLOT_W-1:0]] : ms_q;
`else
  assign lap_view = 1'b0;
  assign outMM    = mm_q;
  assign outSS    = ss_q;
  assign outMS    = ms_q;
`endif

  assign running   = running_q;
  assign lap_count = lap_cnt_q;
  assign lap_full  = full;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed, table-driven bench for lap_stopwatch with CLK_HZ=200, TICK_HZ=100
// (DIV=2: one tick every second running cycle) and LAP_DEPTH=2.
module tb_lap_stopwatch;

  localparam int CLK_HZ    = 200;
  localparam int TICK_HZ   = 100;
  localparam int LAP_DEPTH = 2;
`ifdef LAP_STOPWATCH_RECALL_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ASSERT = 1'b0, in_set = 1'b0, in_op1 = 1'b0, in_op2 = 1'b0;
  logic [6:0] outMM, outSS, outMS;
  logic       running, lap_view, lap_full, overflow;
  logic [3:0] lap_count;

  lap_stopwatch #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clk_2MHz (clk),
    .reset_n  (reset_n),
    .ASSERT   (ASSERT),
    .in_set   (in_set),
    .in_op1   (in_op1),
    .in_op2   (in_op2),
    .outMM    (outMM),
    .outSS    (outSS),
    .outMS    (outMS),
    .running  (running),
    .lap_view (lap_view),
    .lap_count(lap_count),
    .lap_full (lap_full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int a, s, o1, o2, n;
    int mm, ss, ms, run, view, lc, full, ovf;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int mm, input int ss, input int ms,
                         input int run, input int view, input int lc, input int full,
                         input int ovf);
    chk({tag, ".mm"},   int'(outMM),     mm);
    chk({tag, ".ss"},   int'(outSS),     ss);
    chk({tag, ".ms"},   int'(outMS),     ms);
    chk({tag, ".run"},  int'(running),   run);
    chk({tag, ".view"}, int'(lap_view),  view);
    chk({tag, ".lc"},   int'(lap_count), lc);
    chk({tag, ".full"}, int'(lap_full),  full);
    chk({tag, ".ovf"},  int'(overflow),  ovf);
  endtask

  // Apply inputs for n rising edges, then sit 1 time unit after the last edge.
  task automatic apply(input int a, input int s, input int o1, input int o2, input int n);
    ASSERT = a[0]; in_set = s[0]; in_op1 = o1[0]; in_op2 = o2[0];
    repeat (n) @(posedge clk);
    #1;
    ASSERT = 1'b0; in_set = 1'b0; in_op1 = 1'b0; in_op2 = 1'b0;
  endtask

  // Reset asserted, then released between edges (edge+3).
  task automatic do_reset();
    ASSERT = 1'b0; in_set = 1'b0; in_op1 = 1'b0; in_op2 = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    // a s o1 o2 n | mm ss ms run view lc full ovf
    tbl[0]  = '{1,1,0,0, 1, 0,0,0,  1,0,0,0,0};   // start
    tbl[1]  = '{0,0,0,0,74, 0,0,37, 1,0,0,0,0};   // 37 ticks
    tbl[2]  = '{1,0,1,0, 1, 0,0,37, 1,0,1,0,0};   // lap0 = 00:00.37
    tbl[3]  = '{0,0,0,0, 2, 0,0,38, 1,0,1,0,0};
    tbl[4]  = '{1,0,1,0, 1, 0,0,39, 1,0,2,1,0};   // lap1 = pre-tick 00:00.38
    tbl[5]  = '{1,0,1,0, 1, 0,0,39, 1,0,2,1,0};   // dropped: full
    tbl[6]  = '{1,0,0,1, 1, 0,0,(R!=0)?37:40, 1,R,2,1,0};
    tbl[7]  = '{1,0,0,1, 1, 0,0,(R!=0)?38:40, 1,R,2,1,0};
    tbl[8]  = '{1,0,0,1, 1, 0,0,41, 1,0,2,1,0};   // back to live
    tbl[9]  = '{1,1,0,0, 1, 0,0,41, 0,0,2,1,0};   // stop, prescaler left at 1
    tbl[10] = '{0,0,0,0, 1, 0,0,41, 0,0,2,1,0};
    tbl[11] = '{1,1,0,0, 1, 0,0,41, 1,0,2,1,0};   // restart
    tbl[12] = '{0,0,0,0, 1, 0,0,42, 1,0,2,1,0};   // held prescaler ticks at once
    tbl[13] = '{1,1,0,0, 1, 0,0,42, 0,0,2,1,0};   // stop
    tbl[14] = '{0,0,1,0, 1, 0,0,42, 0,0,2,1,0};   // op1 without ASSERT ignored
    tbl[15] = '{1,0,1,0, 1, 0,0,0,  0,0,0,0,0};   // clear
    tbl[16] = '{1,1,0,0, 1, 0,0,0,  1,0,0,0,0};   // start
    tbl[17] = '{0,0,0,0, 1, 0,0,0,  1,0,0,0,0};   // prescaler was cleared: no tick
    tbl[18] = '{0,0,0,0, 1, 0,0,1,  1,0,0,0,0};
    tbl[19] = '{1,1,1,0, 1, 0,0,1,  0,0,0,0,0};   // set beats op1
    tbl[20] = '{1,0,0,1, 1, 0,0,1,  0,0,0,0,0};   // op2 with no laps
    tbl[21] = '{0,1,0,0, 1, 0,0,1,  0,0,0,0,0};   // set without ASSERT ignored

    // Reset state, and one-second count.
    reset_n = 1'b0;
    #2;
    chk_all("reset_async", 0,0,0, 0,0,0,0,0);
    do_reset();
    chk_all("reset", 0,0,0, 0,0,0,0,0);
    apply(1,1,0,0, 1);
    apply(0,0,0,0, 200);
    chk_all("one_sec", 0,1,0, 1,0,0,0,0);

    // Table of commands.
    do_reset();
    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].a, tbl[i].s, tbl[i].o1, tbl[i].o2, tbl[i].n);
      chk_all($sformatf("vec%0d", i), tbl[i].mm, tbl[i].ss, tbl[i].ms,
              tbl[i].run, tbl[i].view, tbl[i].lc, tbl[i].full, tbl[i].ovf);
    end

    // Seconds-to-minutes carry from a preloaded 00:59.99.
    do_reset();
    @(posedge clk); #1;
    force dut.mm_q = 7'd0; force dut.ss_q = 7'd59; force dut.ms_q = 7'd99;
    #1;
    release dut.mm_q; release dut.ss_q; release dut.ms_q;
    apply(1,1,0,0, 1);
    apply(0,0,0,0, 2);
    chk_all("carry_mm", 1,0,0, 1,0,0,0,0);

    // Saturation from a preloaded 99:59.98.
    apply(1,1,0,0, 1);
    force dut.mm_q = 7'd99; force dut.ss_q = 7'd59; force dut.ms_q = 7'd98;
    #1;
    release dut.mm_q; release dut.ss_q; release dut.ms_q;
    apply(1,1,0,0, 1);
    apply(0,0,0,0, 1);
    chk_all("sat_last", 99,59,99, 1,0,0,0,0);
    apply(0,0,0,0, 2);
    chk_all("sat_hit", 99,59,99, 1,0,0,0,1);
    apply(0,0,0,0, 20);
    chk_all("sat_hold", 99,59,99, 1,0,0,0,1);
    apply(1,1,0,0, 1);
    apply(1,0,1,0, 1);
    chk_all("sat_clear", 0,0,0, 0,0,0,0,0);

    // Asynchronous reset between edges while counting with a stored lap.
    apply(1,1,0,0, 1);
    apply(0,0,0,0, 30);
    apply(1,0,1,0, 1);
    apply(1,0,0,1, 1);
    chk_all("pre_rst", 0,0,(R!=0)?15:16, 1,R,1,0,0);
    #3;
    reset_n = 1'b0;
    #1;
    chk_all("mid_rst", 0,0,0, 0,0,0,0,0);
    @(posedge clk); #1;
    chk_all("rst_hold", 0,0,0, 0,0,0,0,0);
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
